// File: rtl/lcd_spi_slave_rx.sv
// rtl/lcd_spi_slave_rx.sv - SPI receiver for the 9-bit LCD link with {dc,byte} FWFT FIFO (optional LCD_SPI_RX_WORD_CNT_EN)
module lcd_spi_slave_rx #(
   parameter int DEPTH_LOG2  = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  spi_csn,
   input  logic                  spi_clk,
   input  logic                  spi_mosi,
   input  logic                  spi_dc,
   input  logic                  rd_en,
   output logic [8:0]            rd_data,
   output logic                  empty,
   output logic                  full,
   output logic [DEPTH_LOG2:0]   level,
   output logic                  overrun,
   output logic                  frame_err,
   input  logic                  err_clr,
   input  logic                  irq_en,
   output logic                  irq
`ifdef LCD_SPI_RX_WORD_CNT_EN
   ,
   output logic [15:0]           word_cnt
`endif
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL_LEVEL = {1'b1, {DEPTH_LOG2{1'b0}}};

   typedef enum logic {IDLE, SHIFT} state_t;

   logic [SYNC_STAGES-1:0] csn_sync, sclk_sync, mosi_sync, dc_sync;
   logic                   csn_d, sclk_d, mosi_d, dc_d, sclk_rise;
   state_t                 state;
   logic [2:0]             bit_cnt;
   logic [6:0]             shift;
   logic                   csn_armed;
   logic                   push_req;
   logic [8:0]             push_word;
   logic [8:0]             mem [DEPTH];
   logic [DEPTH_LOG2-1:0]  wr_ptr, rd_ptr;
   logic                   accept, pop;

   // Synchronize the four asynchronous SPI inputs into the clk domain
   always_ff @(posedge clk) begin
      if (rst) begin
         csn_sync  <= '0;
         sclk_sync <= '0;
         mosi_sync <= '0;
         dc_sync   <= '0;
      end else begin
         csn_sync  <= {csn_sync[SYNC_STAGES-2:0], spi_csn};
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
         dc_sync   <= {dc_sync[SYNC_STAGES-2:0], spi_dc};
      end
   end

   // Edge-detect flop stage; data/csn are delayed alongside so they line up with the registered rise pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         csn_d     <= 1'b0;
         sclk_d    <= 1'b0;
         mosi_d    <= 1'b0;
         dc_d      <= 1'b0;
         sclk_rise <= 1'b0;
      end else begin
         csn_d     <= csn_sync[SYNC_STAGES-1];
         sclk_d    <= sclk_sync[SYNC_STAGES-1];
         mosi_d    <= mosi_sync[SYNC_STAGES-1];
         dc_d      <= dc_sync[SYNC_STAGES-1];
         sclk_rise <= sclk_sync[SYNC_STAGES-1] & ~sclk_d;
      end
   end

   // Receive FSM: shifts bits, emits a push request per full word, flags short frames
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         bit_cnt   <= 3'd0;
         shift     <= 7'd0;
         csn_armed <= 1'b0;
         push_req  <= 1'b0;
         push_word <= 9'd0;
         frame_err <= 1'b0;
      end else begin
         push_req <= 1'b0;
         if (err_clr)
            frame_err <= 1'b0;
         case (state)
            IDLE: begin
               bit_cnt <= 3'd0;
               // a select is only honoured after csn has been seen high since reset
               if (csn_d)
                  csn_armed <= 1'b1;
               if (!csn_d && csn_armed)
                  state <= SHIFT;
            end
            SHIFT: begin
               if (csn_d) begin
                  state   <= IDLE;
                  bit_cnt <= 3'd0;
                  if (bit_cnt != 3'd0)
                     frame_err <= 1'b1;
               end else if (sclk_rise) begin
                  shift <= {shift[5:0], mosi_d};
                  if (bit_cnt == 3'd7) begin
                     push_req  <= 1'b1;
                     push_word <= {dc_d, shift, mosi_d};
                     bit_cnt   <= 3'd0;
                  end else begin
                     bit_cnt <= bit_cnt + 3'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign empty   = (level == '0);
   assign full    = (level == FULL_LEVEL);
   assign pop     = rd_en & ~empty;
   assign accept  = push_req & (~full | rd_en);
   assign rd_data = empty ? 9'd0 : mem[rd_ptr];

   // FIFO storage; when full with a simultaneous pop the new word overwrites the departing head slot
   always_ff @(posedge clk) begin
      if (accept)
         mem[wr_ptr] <= push_word;
   end

   // FIFO pointers, level and overrun flag
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level   <= '0;
         overrun <= 1'b0;
      end else begin
         if (accept)
            wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
         if (pop)
            rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
         level <= level + {{DEPTH_LOG2{1'b0}}, accept} - {{DEPTH_LOG2{1'b0}}, pop};
         if (err_clr)
            overrun <= 1'b0;
         if (push_req && !accept)
            overrun <= 1'b1;
      end
   end

   // Registered interrupt
   always_ff @(posedge clk) begin
      if (rst)
         irq <= 1'b0;
      else
         irq <= irq_en & (~empty | overrun | frame_err);
   end

`ifdef LCD_SPI_RX_WORD_CNT_EN
   // Count of words accepted into the FIFO, wrapping
   always_ff @(posedge clk) begin
      if (rst)
         word_cnt <= 16'd0;
      else if (accept)
         word_cnt <= word_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_lcd_spi_slave_rx.sv
// tb/tb_lcd_spi_slave_rx.sv - self-checking bench for lcd_spi_slave_rx
module tb_lcd_spi_slave_rx;

   localparam int SYNC = 2;

   logic        clk = 1'b0;
   logic        rst, spi_csn, spi_clk, spi_mosi, spi_dc, rd_en, err_clr, irq_en;
   logic [8:0]  rd_data;
   logic        empty, full, overrun, frame_err, irq;
   logic [4:0]  level;
`ifdef LCD_SPI_RX_WORD_CNT_EN
   logic [15:0] word_cnt;
`endif

   int          n_chk = 0;
   int          n_pass = 0;
   logic [8:0]  q[$];
   bit          ov_m, fe_m;
   int          cnt_m;

   lcd_spi_slave_rx #(.DEPTH_LOG2(4), .SYNC_STAGES(SYNC)) dut (
      .clk(clk), .rst(rst), .spi_csn(spi_csn), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
      .spi_dc(spi_dc), .rd_en(rd_en), .rd_data(rd_data), .empty(empty), .full(full),
      .level(level), .overrun(overrun), .frame_err(frame_err), .err_clr(err_clr),
      .irq_en(irq_en), .irq(irq)
`ifdef LCD_SPI_RX_WORD_CNT_EN
      , .word_cnt(word_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_state();
      bit busy;
      busy = (q.size() != 0) || ov_m || fe_m;
      check("level", level, q.size());
      check("empty", empty, q.size() == 0);
      check("full", full, q.size() == 16);
      check("overrun", overrun, ov_m);
      check("frame_err", frame_err, fe_m);
      check("irq", irq, irq_en & busy);
      if (q.size() != 0) check("head", rd_data, q[0]);
      else check("rd_data_empty", rd_data, 9'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      q.delete();
      ov_m = 0; fe_m = 0; cnt_m = 0;
   endtask

   task automatic csn_high();
      spi_csn = 1'b1;
      tick(6);
   endtask

   task automatic csn_low();
      spi_csn = 1'b0;
      tick(3);
   endtask

   task automatic send_bits(input logic [7:0] b, input bit dc, input int nbits);
      for (int i = 7; i > 7 - nbits; i--) begin
         spi_mosi = b[i]; spi_dc = dc; spi_clk = 1'b0;
         tick(2);
         spi_clk = 1'b1;
         tick(2);
      end
      spi_clk = 1'b0;
      tick(2);
   endtask

   // full word; rx=0 means the receiver is expected to ignore it
   task automatic send_word(input logic [7:0] b, input bit dc, input bit rx, input bit pop_at_push, input bit lat_chk);
      bit was_full;
      for (int i = 7; i >= 0; i--) begin
         spi_mosi = b[i]; spi_dc = dc; spi_clk = 1'b0;
         tick(2);
         spi_clk = 1'b1;
         if (i > 0) tick(2);
      end
      // c counts clk edges from the first edge sampling the 8th spi_clk high
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         if (c == 1) spi_clk = 1'b0;
         if (lat_chk && c == SYNC + 1) check("latency_before", empty, 1'b1);
         if (lat_chk && c == SYNC + 2) check("latency_at", empty, 1'b0);
         if (pop_at_push && c == SYNC + 1) rd_en = 1'b1;
         if (c == SYNC + 2) rd_en = 1'b0;
      end
      if (rx) begin
         was_full = (q.size() == 16);
         if (pop_at_push && q.size() != 0) void'(q.pop_front());
         if (!was_full || pop_at_push) begin
            q.push_back({dc, b});
            cnt_m++;
         end else begin
            ov_m = 1;
         end
      end
   endtask

   task automatic pop_word();
      check("pop_data", rd_data, q[0]);
      rd_en = 1'b1;
      tick(1);
      rd_en = 1'b0;
      tick(1);
      void'(q.pop_front());
   endtask

   task automatic clear_errs();
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
      tick(1);
      ov_m = 0; fe_m = 0;
   endtask

   initial begin
      rst = 1'b1; spi_csn = 1'b1; spi_clk = 1'b0; spi_mosi = 1'b0; spi_dc = 1'b0;
      rd_en = 1'b0; err_clr = 1'b0; irq_en = 1'b0;
      tick(1);
      do_reset();
      check_state();

      // single word with latency check
      csn_high();
      csn_low();
      send_word(8'hA5, 1'b1, 1'b1, 1'b0, 1'b1);
      check_state();
      check("first_word", rd_data, 9'h1A5);

      // consecutive words under one select
      send_word(8'h2C, 1'b0, 1'b1, 1'b0, 1'b0);
      send_word(8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
      send_word(8'hFF, 1'b1, 1'b1, 1'b0, 1'b0);
      check_state();
      while (q.size() != 0) pop_word();
      check_state();

      // fill past capacity
      for (int i = 0; i < 17; i++) begin
         send_word(8'(i * 13 + 7), i[0], 1'b1, 1'b0, 1'b0);
         if (i >= 15) check_state();
      end
      while (q.size() != 0) pop_word();
      check_state();
      clear_errs();
      check_state();

      // short frame then a good word
      send_bits(8'hE0, 1'b0, 3);
      spi_csn = 1'b1;
      tick(6);
      fe_m = 1;
      check_state();
      csn_low();
      send_word(8'h3C, 1'b0, 1'b1, 1'b0, 1'b0);
      check_state();
      check("after_frame_err", rd_data, 9'h03C);
      clear_errs();
      check_state();
      pop_word();

      // full FIFO with pop coinciding with the 17th push
      for (int i = 0; i < 16; i++) send_word(8'($urandom), 1'($urandom), 1'b1, 1'b0, 1'b0);
      check_state();
      send_word(8'h96, 1'b1, 1'b1, 1'b1, 1'b0);
      check_state();
      check("tail_new", q[15], 9'h196);
      while (q.size() != 0) pop_word();
      check_state();

      // interrupt
      irq_en = 1'b1;
      tick(2);
      check_state();
      send_word(8'h11, 1'b0, 1'b1, 1'b0, 1'b0);
      tick(1);
      check("irq_set", irq, 1'b1);
      pop_word();
      check("irq_clr", irq, 1'b0);

      // reset mid-word: remainder under the same select must be ignored
      send_bits(8'hF0, 1'b1, 4);
      do_reset();
`ifdef LCD_SPI_RX_WORD_CNT_EN
      check("word_cnt_rst", word_cnt, 16'd0);
`endif
      tick(4);
      send_word(8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
      check_state();
      csn_high();
      csn_low();
      send_word(8'h5A, 1'b0, 1'b1, 1'b0, 1'b0);
      check_state();
`ifdef LCD_SPI_RX_WORD_CNT_EN
      check("word_cnt_one", word_cnt, 16'd1);
`endif

      // randomized traffic against the queue model
      for (int it = 0; it < 60; it++) begin
         int r;
         irq_en = 1'($urandom);
         r = $urandom_range(0, 9);
         if (r < 6) begin
            send_word(8'($urandom), 1'($urandom), 1'b1, ($urandom_range(0, 3) == 0), 1'b0);
         end else if (r < 8) begin
            int k;
            k = $urandom_range(1, 4);
            for (int j = 0; j < k && q.size() != 0; j++) pop_word();
         end else if (r == 8) begin
            send_bits(8'($urandom), 1'b0, $urandom_range(1, 7));
            spi_csn = 1'b1;
            tick(6);
            fe_m = 1;
            csn_low();
         end else begin
            clear_errs();
         end
         tick(1);
         check_state();
      end
`ifdef LCD_SPI_RX_WORD_CNT_EN
      check("word_cnt_rand", word_cnt, 16'(cnt_m));
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
